// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants
package mips_pkg;
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} t_fetch_state;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, one-outstanding imem fetch and IF/ID pipeline register
module fetch_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4
);
    t_fetch_state state;
    logic [ADDR_W-1:0] pc, old_pc, target, buf_pc4, pc4, rpc;
    logic [DATA_W-1:0] buf_instr;
    logic done;

    assign imem_req = state != HOLD && !rst;
    assign imem_addr = state == DRAIN ? old_pc : pc;
    assign done = imem_req && imem_rvalid;
    assign pc4 = pc + ADDR_W'(4);
    assign rpc = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            old_pc <= RESET_PC;
            target <= RESET_PC;
            buf_instr <= DATA_W'(NOP_INSTR);
            buf_pc4 <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= DATA_W'(NOP_INSTR);
            if_id_pc4 <= '0;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
            if_id_instr <= DATA_W'(NOP_INSTR);
            if (state == HOLD || done) begin
                pc <= rpc;
                state <= FETCH;
            end else begin
                // the in-flight request must still complete; remember where to go afterwards
                target <= rpc;
                if (state == FETCH) old_pc <= pc;
                state <= DRAIN;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (done && stall) begin
                        buf_instr <= imem_rdata;
                        buf_pc4 <= pc4;
                        pc <= pc4;
                        state <= HOLD;
                    end else if (done) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= imem_rdata;
                        if_id_pc4 <= pc4;
                        pc <= pc4;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= DATA_W'(NOP_INSTR);
                    end
                end
                DRAIN: begin
                    if (done) begin
                        pc <= target;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= buf_instr;
                        if_id_pc4 <= buf_pc4;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic against a request/decoder-level model
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req;
    logic [31:0] imem_addr;
    logic imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic stall = 1'b0;
    logic redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    int passed = 0;
    int total = 0;

    // model: address of the outstanding request, whether its data is stale, one held word
    logic [31:0] m_addr, m_target, m_instr, m_pc4, m_hinstr, m_hpc4;
    bit m_valid, m_stale, m_held;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit rv, input bit st, input bit rd, input logic [31:0] rpc);
        bit exp_req, done;
        logic [31:0] tgt;
        rst = r;
        imem_rvalid = rv;
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        imem_rdata = $urandom;
        tgt = rpc & 32'hFFFF_FFFC;
        #1;
        exp_req = !r && !m_held;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_addr);
        done = exp_req && rv;
        if (r) begin
            m_addr = 32'h0; m_stale = 0; m_held = 0;
            m_valid = 0; m_instr = 0; m_pc4 = 0;
        end else if (rd) begin
            m_valid = 0; m_instr = 0;
            if (done || m_held) begin
                m_addr = tgt; m_stale = 0;
            end else begin
                m_target = tgt; m_stale = 1;
            end
            m_held = 0;
        end else if (done && m_stale) begin
            m_addr = m_target; m_stale = 0;
        end else if (done) begin
            if (st) begin
                m_held = 1; m_hinstr = imem_rdata; m_hpc4 = m_addr + 4;
            end else begin
                m_valid = 1; m_instr = imem_rdata; m_pc4 = m_addr + 4;
            end
            m_addr = m_addr + 4;
        end else if (m_held) begin
            if (!st) begin
                m_valid = 1; m_instr = m_hinstr; m_pc4 = m_hpc4; m_held = 0;
            end
        end else if (!st) begin
            m_valid = 0; m_instr = 0;
        end
        @(negedge clk);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("if_id_instr", if_id_instr, m_valid ? m_instr : 32'h0);
        if (m_valid || r) chk("if_id_pc4", if_id_pc4, m_pc4);
    endtask

    initial begin
        m_addr = 0; m_target = 0; m_instr = 0; m_pc4 = 0; m_hinstr = 0; m_hpc4 = 0;
        m_valid = 0; m_stale = 0; m_held = 1;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // zero-wait streaming
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, 0);
            chk("s1_pc4", if_id_pc4, 32'(4 * i));
        end
        // slow memory
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("s2_addr", imem_addr, 32'h0);
        end
        step(0, 1, 0, 0, 0);
        chk("s2_valid", {31'b0, if_id_valid}, 32'h1);
        // stall at the completion of 0x8
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0);
            chk("s3_hold_pc4", if_id_pc4, 32'h8);
            chk("s3_req_low", {31'b0, imem_req}, 32'h0);
        end
        step(0, 1, 0, 0, 0);
        chk("s3_release_pc4", if_id_pc4, 32'hC);
        chk("s3_next_addr", imem_addr, 32'hC);
        // redirect while 0x10 is in flight
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h40);
        chk("s4_drain_addr", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("s4_dropped", {31'b0, if_id_valid}, 32'h0);
        chk("s4_next_addr", imem_addr, 32'h40);
        // redirect beats stall and completion
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 32'h43);
        chk("s5_valid", {31'b0, if_id_valid}, 32'h0);
        chk("s5_instr", if_id_instr, 32'h0);
        chk("s5_addr", imem_addr, 32'h40);
        // reset in DRAIN, reset in HOLD, PC wrap
        step(0, 0, 0, 1, 32'h80);
        step(1, 0, 0, 0, 0);
        chk("s6_drain_rst_addr", imem_addr, 32'h0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("s6_hold_rst_valid", {31'b0, if_id_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("s6_buf_dropped", if_id_pc4, 32'h4);
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        chk("s6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0);
        chk("s6_wrap_pc4", if_id_pc4, 32'h0);
        chk("s6_wrap_next", imem_addr, 32'h0);
        // random traffic
        for (int i = 0; i < 2000; i++)
            step($urandom % 64 == 0, $urandom % 3 != 0, $urandom % 4 == 0,
                 $urandom % 8 == 0, $urandom);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
